// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with 16x oversampling and optional even parity.
//
// Optional feature: define UART_RX_PARITY_EN to expect an even parity bit
// between the last data bit and the stop bit (frame = start+8+parity+stop).
// Without it the frame is start+8+stop and parity_err is always 0.
//
// Parameters:
//   CLK_FREQ   clk frequency in Hz
//   BAUD       serial bit rate in bit/s
// Ports:
//   clk        system clock, all state on rising edge
//   rst_n      asynchronous active-low reset
//   rx         asynchronous serial input, idle high, LSB first
//   dout       last correctly received byte, held until the next good byte
//   dout_valid one-cycle pulse when dout is updated
//   frame_err  one-cycle pulse when the stop bit is sampled low
//   parity_err one-cycle pulse on parity mismatch
//   busy       high whenever a frame is in progress (state != IDLE)
module uart_rx #(
   parameter int CLK_FREQ = 50_000_000,
   parameter int BAUD     = 115200
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] dout,
   output logic       dout_valid,
   output logic       frame_err,
   output logic       parity_err,
   output logic       busy
);

   localparam int DIV_RAW = CLK_FREQ / (16 * BAUD);
   localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
`endif

   state_t        state, state_nxt;
   logic [1:0]    sync;
   logic          rx_s;
   logic [DW-1:0] div_cnt;
   logic          tick;
   logic [3:0]    os_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;
   logic          mid_bit;   // 16th tick of a bit period after the start-bit centre
   logic          par_bad;
   logic          dv_nxt, fe_nxt, pe_nxt;

   // Two-flop synchronizer; resets to the idle (high) line level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync <= 2'b11;
      else        sync <= {sync[0], rx};
   end
   assign rx_s = sync[1];

   assign busy = (state != IDLE);

   // Tick divider is held at 0 in IDLE so every frame starts with a fresh phase.
   assign tick = busy && (div_cnt == DW'(DIV - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  div_cnt <= '0;
      else if (!busy || tick)      div_cnt <= '0;
      else                         div_cnt <= div_cnt + DW'(1);
   end

   assign mid_bit = tick && (os_cnt == 4'hF);

`ifdef UART_RX_PARITY_EN
   logic par_bit;
   assign par_bad = ^{shift, par_bit};
`else
   assign par_bad = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      dv_nxt    = 1'b0;
      fe_nxt    = 1'b0;
      pe_nxt    = 1'b0;
      case (state)
         IDLE:      if (!rx_s) state_nxt = START;
         // Re-check the line at the start-bit centre to reject glitches.
         START:     if (tick && os_cnt == 4'd7) state_nxt = rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
         DATA:      if (mid_bit && bit_idx == 3'd7) state_nxt = PARITY;
         PARITY:    if (mid_bit) state_nxt = STOP;
`else
         DATA:      if (mid_bit && bit_idx == 3'd7) state_nxt = STOP;
`endif
         STOP: begin
            if (mid_bit) begin
               if (!rx_s) begin
                  fe_nxt    = 1'b1;
                  state_nxt = WAIT_IDLE;
               end else if (par_bad) begin
                  pe_nxt    = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  dv_nxt    = 1'b1;
                  state_nxt = IDLE;
               end
            end
         end
         // Line held low past the stop bit (break): wait for it to recover.
         WAIT_IDLE: if (rx_s) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         os_cnt  <= '0;
         bit_idx <= '0;
         shift   <= '0;
`ifdef UART_RX_PARITY_EN
         par_bit <= 1'b0;
`endif
      end else if (!busy) begin
         os_cnt <= '0;
      end else if (tick) begin
         case (state)
            START: begin
               // Realign the oversample counter on the start-bit centre.
               if (os_cnt == 4'd7) begin
                  os_cnt  <= '0;
                  bit_idx <= '0;
               end else begin
                  os_cnt <= os_cnt + 4'd1;
               end
            end
            DATA: begin
               os_cnt <= os_cnt + 4'd1;
               if (os_cnt == 4'hF) begin
                  shift[bit_idx] <= rx_s;
                  bit_idx        <= bit_idx + 3'd1;
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               os_cnt <= os_cnt + 4'd1;
               if (os_cnt == 4'hF) par_bit <= rx_s;
            end
`endif
            default: os_cnt <= os_cnt + 4'd1;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout       <= 8'h00;
         dout_valid <= 1'b0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         dout_valid <= dv_nxt;
         frame_err  <= fe_nxt;
         parity_err <= pe_nxt;
         if (dv_nxt) dout <= shift;
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx at CLK_FREQ=3.2 MHz, BAUD=100 kbit/s (32 clk per bit).
// Frames are driven bit by bit; a monitor turns output pulses into events that
// are matched against outcomes predicted from the frame contents.
module tb_uart_rx;

   localparam int CLK_FREQ = 3_200_000;
   localparam int BAUD     = 100_000;
   localparam int BIT_CLK  = 32;
`ifdef UART_RX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif

   localparam int K_VALID = 0;
   localparam int K_FERR  = 1;
   localparam int K_PERR  = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx = 1'b1;
   logic [7:0] dout;
   logic       dout_valid, frame_err, parity_err, busy;

   uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
      .clk(clk), .rst_n(rst_n), .rx(rx), .dout(dout), .dout_valid(dout_valid),
      .frame_err(frame_err), .parity_err(parity_err), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         kind;
      logic [7:0] d;
      longint     cyc;
   } ev_t;

   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         hold;      // extra clk the line stays at the stop level
      int         kind;
      logic [7:0] exp_dout;
   } vec_t;

   ev_t        evq[$];
   int         n_cmp = 0;
   int         n_bad = 0;
   longint     cyc_cnt = 0;
   logic [7:0] prev_dout = 8'h00;
   logic [7:0] model_dout = 8'h00;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: records every pulse, checks exclusivity and that dout only moves with dout_valid.
   always @(negedge clk) begin
      ev_t e;
      if (!rst_n) begin
         prev_dout = dout;
      end else begin
         if (dout_valid || frame_err || parity_err) begin
            chk("pulse_onehot", 32'(dout_valid) + 32'(frame_err) + 32'(parity_err), 32'd1);
            e.kind = dout_valid ? K_VALID : (frame_err ? K_FERR : K_PERR);
            e.d    = dout;
            e.cyc  = cyc_cnt;
            evq.push_back(e);
         end
         if (dout !== prev_dout) chk("dout_moves_only_with_valid", 32'(dout_valid), 32'd1);
         prev_dout = dout;
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop, input logic p);
      rx = 1'b0; cyc(BIT_CLK);
      for (int i = 0; i < 8; i++) begin rx = d[i]; cyc(BIT_CLK); end
      if (PAR != 0) begin rx = p; cyc(BIT_CLK); end
      rx = stop; cyc(BIT_CLK);
   endtask

   function automatic int model_kind(input logic [7:0] d, input logic stop, input logic p);
      if (!stop) return K_FERR;
      if (PAR != 0 && ((^d) ^ p)) return K_PERR;
      return K_VALID;
   endfunction

   task automatic expect_ev(input string name, input int kind, input logic [7:0] d);
      ev_t e;
      n_cmp++;
      if (evq.size() == 0) begin
         n_bad++;
         $display("FAIL %s: got no pulse, expected kind %0d dout %0h", name, kind, d);
      end else begin
         e = evq.pop_front();
         if (e.kind != kind || e.d !== d) begin
            n_bad++;
            $display("FAIL %s: got kind %0d dout %0h, expected kind %0d dout %0h",
                     name, e.kind, e.d, kind, d);
         end
      end
   endtask

   task automatic expect_none(input string name);
      chk(name, 32'(evq.size()), 32'd0);
      evq.delete();
   endtask

   vec_t vecs[6];

   initial begin
      ev_t e0, e1;
      bit  ok;
      vecs[0] = '{8'hA5, 1'b1, 0,   K_VALID, 8'hA5};
      vecs[1] = '{8'h00, 1'b1, 0,   K_VALID, 8'h00};
      vecs[2] = '{8'hFF, 1'b1, 0,   K_VALID, 8'hFF};
      vecs[3] = '{8'h55, 1'b0, 100, K_FERR,  8'hFF};
      vecs[4] = '{8'h81, 1'b1, 0,   K_VALID, 8'h81};
      vecs[5] = '{8'h6E, 1'b1, 7,   K_VALID, 8'h6E};

      // Reset state
      cyc(5);
      chk("rst_dout", 32'(dout), 32'h00);
      chk("rst_dout_valid", 32'(dout_valid), 0);
      chk("rst_frame_err", 32'(frame_err), 0);
      chk("rst_parity_err", 32'(parity_err), 0);
      chk("rst_busy", 32'(busy), 0);
      rst_n = 1'b1;
      cyc(10);

      // Directed table
      foreach (vecs[i]) begin
         send_frame(vecs[i].data, vecs[i].stop, ^vecs[i].data);
         cyc(vecs[i].hold);
         if (!vecs[i].stop) chk($sformatf("vec%0d_busy_wait_idle", i), 32'(busy), 1);
         rx = 1'b1;
         cyc(20);
         expect_ev($sformatf("vec%0d_event", i), vecs[i].kind, vecs[i].exp_dout);
         expect_none($sformatf("vec%0d_single_pulse", i));
         chk($sformatf("vec%0d_busy_after", i), 32'(busy), 0);
      end
      model_dout = 8'h6E;

      // Back-to-back frames
      send_frame(8'h3C, 1'b1, ^8'h3C);
      send_frame(8'hC3, 1'b1, ^8'hC3);
      rx = 1'b1;
      cyc(20);
      chk("b2b_count", 32'(evq.size()), 32'd2);
      if (evq.size() == 2) begin
         e0 = evq[0]; e1 = evq[1];
         chk("b2b_first", {e0.kind[7:0], e0.d}, {8'(K_VALID), 8'h3C});
         chk("b2b_second", {e1.kind[7:0], e1.d}, {8'(K_VALID), 8'hC3});
         chk("b2b_spacing", 32'(e1.cyc - e0.cyc), 32'(BIT_CLK * (10 + PAR)));
      end
      evq.delete();
      model_dout = 8'hC3;

      // Glitch in IDLE
      rx = 1'b0; cyc(10);
      chk("glitch_busy_during", 32'(busy), 1);
      rx = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 18 && !ok; i++) begin
         cyc(1);
         if (!busy) ok = 1'b1;
      end
      chk("glitch_busy_low_in_18", 32'(ok), 1);
      cyc(40);
      expect_none("glitch_no_pulse");
      chk("glitch_dout_held", 32'(dout), 32'hC3);

      // Reset during bit 4 of 8'hFF
      rx = 1'b0; cyc(BIT_CLK);
      rx = 1'b1; cyc(4 * BIT_CLK + 16);
      rst_n = 1'b0; cyc(3);
      chk("midrst_dout", 32'(dout), 32'h00);
      chk("midrst_busy", 32'(busy), 0);
      rst_n = 1'b1;
      cyc(16 + (3 + PAR + 1) * BIT_CLK);
      model_dout = 8'h00;
      send_frame(8'h12, 1'b1, ^8'h12);
      rx = 1'b1; cyc(20);
      expect_ev("midrst_then_12", K_VALID, 8'h12);
      expect_none("midrst_single_pulse");
      model_dout = 8'h12;

`ifdef UART_RX_PARITY_EN
      send_frame(8'h07, 1'b1, 1'b0);
      rx = 1'b1; cyc(20);
      expect_ev("parity_bad", K_PERR, 8'h12);
      expect_none("parity_bad_single");
      send_frame(8'h07, 1'b1, 1'b1);
      rx = 1'b1; cyc(20);
      expect_ev("parity_good", K_VALID, 8'h07);
      expect_none("parity_good_single");
      model_dout = 8'h07;
`endif

      // Randomized frames against the outcome model
      for (int n = 0; n < 30; n++) begin
         logic [7:0] d;
         logic       stop, p;
         int         k, gap;
         d    = 8'($urandom);
         stop = ($urandom_range(0, 4) != 0);
         p    = (^d) ^ ($urandom_range(0, 3) == 0);
         gap  = stop ? $urandom_range(0, 40) : $urandom_range(5, 40);
         k    = model_kind(d, stop, p);
         if (k == K_VALID) model_dout = d;
         send_frame(d, stop, p);
         if (!stop) cyc($urandom_range(0, 50));
         rx = 1'b1;
         cyc(gap);
         expect_ev($sformatf("rand%0d", n), k, model_dout);
      end
      cyc(20);
      expect_none("rand_no_extra");
      chk("final_busy", 32'(busy), 0);
      chk("final_dout", 32'(dout), 32'(model_dout));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, frequency of clk in Hz.
REQ-002 Parameter BAUD, default 115200, serial bit rate in bit/s.
REQ-003 Port clk  input  1  system clock; all state on rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port rx  input  1  asynchronous serial line; idle high; 8 data bits, LSB first, 1 stop bit.
REQ-006 Port dout  output  8  last correctly received byte; held until the next good byte.
REQ-007 Port dout_valid  output  1  one-cycle pulse when dout is updated.
REQ-008 Port frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
REQ-009 Port parity_err  output  1  one-cycle pulse on parity mismatch; constant 0 when parity is compiled out.
REQ-010 Port busy  output  1  high in every state except IDLE.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer (both flops reset to 1) before any use; rx_s denotes its output.
REQ-012 The tick divider SHALL be DIV = CLK_FREQ/(16*BAUD) using integer truncation, minimum 1; a counter 0..DIV-1 SHALL emit one-cycle tick at wrap and run only while busy, restarting at 0 on leaving IDLE.
REQ-013 The states SHALL be IDLE, START, DATA, PARITY (macro only), STOP and WAIT_IDLE.
REQ-014 IDLE: when rx_s=0, go to START with the tick counter and the 4-bit oversample counter cleared.
REQ-015 START: on the 8th tick (mid start bit), go back to IDLE without a pulse if rx_s=1 (glitch); otherwise go to DATA with the bit index at 0.
REQ-016 DATA: every 16th tick, sample rx_s into shift[bit index] (LSB first); after index 7, go to PARITY if enabled, else STOP.
REQ-017 STOP: on the 16th tick, sample rx_s; 1 with no parity error: load dout, pulse dout_valid, go to IDLE; 1 with parity error: pulse parity_err, dout unchanged, go to IDLE; 0: pulse frame_err, dout unchanged, go to WAIT_IDLE.
REQ-018 WAIT_IDLE: remain until rx_s=1 (break/line-low condition), then go to IDLE; no pulses are issued.
REQ-019 The pulses SHALL assert in the cycle after the stop-bit sample edge and last exactly one cycle; dout_valid, frame_err and parity_err SHALL never assert together.
REQ-020 A falling edge during STOP or WAIT_IDLE SHALL NOT start a new frame; a start bit is recognised only from IDLE.
REQ-021 Back-to-back frames (stop bit directly followed by a start bit) SHALL be received with no lost byte.

Reset
REQ-022 While rst_n=0: state=IDLE, counters=0, shift=0, dout=8'h00, dout_valid=0, frame_err=0, parity_err=0, busy=0, synchronizer=1.
REQ-023 Deassertion of rst_n mid-frame SHALL discard the partial frame; reception resumes at the next falling edge seen in IDLE.

Configuration
REQ-024 Macro UART_RX_PARITY_EN defined: PARITY state inserted after DATA; the 9th bit is sampled on its 16th tick and checked for even parity (XOR of 8 data bits and parity bit = 0); a mismatch is flagged at STOP per REQ-017.
REQ-025 Macro UART_RX_PARITY_EN undefined: PARITY state absent; frame = start+8+stop; parity_err tied 0.

Verification (CLK_FREQ=3_200_000, BAUD=100_000 -> DIV=2, 32 clk/bit)
REQ-026 Send 8'hA5 with a valid stop -> dout=8'hA5, one dout_valid pulse, busy low afterwards, no error pulses.
REQ-027 Send 8'h3C then 8'hC3 back-to-back -> two dout_valid pulses 320 clk apart (352 with parity), with dout 8'h3C then 8'hC3.
REQ-028 Send 8'h55 with stop=0, hold rx low 100 clk, then release -> one frame_err pulse, dout keeps its previous value, state WAIT_IDLE until rx high.
REQ-029 Pulse rx low for 10 clk in IDLE -> no output pulse, busy returns low within 18 clk.
REQ-030 Assert rst_n=0 for 3 clk during bit 4 of 8'hFF, then send 8'h12 -> dout=8'h12 only, with exactly one dout_valid pulse.
REQ-031 With UART_RX_PARITY_EN defined, send 8'h07 with parity bit 0 -> parity_err pulse, no dout_valid; with parity bit 1 -> dout=8'h07.
